// File: rtl/reg_cmd_master_pkg.sv
// Shared definitions for the MCDF register command bus: command encodings,
// master FSM states and the register address map.
package mcdf_reg_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_RD   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_WR     = 4'b0010,
    ST_RD_PRE = 4'b0100,
    ST_RD     = 4'b1000
  } state_t;

  localparam logic [7:0] REG_SLV0_CTRL = 8'h00;
  localparam logic [7:0] REG_SLV1_CTRL = 8'h04;
  localparam logic [7:0] REG_SLV2_CTRL = 8'h08;
  localparam logic [7:0] REG_SLV0_STAT = 8'h0C;
  localparam logic [7:0] REG_LAST      = 8'hFF;

endpackage

// File: rtl/reg_cmd_master_if.sv
// Request/response channels plus the register command bus of reg_cmd_master.
// The master modport is the command initiator; slave is everything around it.
interface reg_cmd_master_if #(
  parameter int CMD_WIDE = 32,
  parameter int WL_WIDE  = 8
);

  logic                req_valid;
  logic                req_ready;
  logic                req_wr;
  logic [WL_WIDE-1:0]  req_addr;
  logic [CMD_WIDE-1:0] req_wdata;

  logic [1:0]          cmd;
  logic [WL_WIDE-1:0]  cmd_addr;
  logic [CMD_WIDE-1:0] cmd_data_in;
  logic [CMD_WIDE-1:0] cmd_data_out;
  logic                wr_done;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [CMD_WIDE-1:0] rsp_rdata;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, cmd_data_out, rsp_ready,
    output req_ready, cmd, cmd_addr, cmd_data_in, wr_done, rsp_valid, rsp_rdata
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, cmd_data_out, rsp_ready,
    input  req_ready, cmd, cmd_addr, cmd_data_in, wr_done, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/reg_cmd_master.sv
// Register command bus initiator: one outstanding WR/RD request at a time,
// read data returned on a held valid/ready response channel.
module reg_cmd_master
  import mcdf_reg_pkg::*;
#(
  parameter int CMD_WIDE = 32,
  parameter int WL_WIDE  = 8,
  parameter int RD_LAT   = 1
) (
  input logic              clk,
  input logic              rst_n,
  reg_cmd_master_if.master bus
);

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [1:0]          cmd_q, cmd_nxt;
  logic [WL_WIDE-1:0]  addr_q, addr_nxt;
  logic [CMD_WIDE-1:0] wdata_q, wdata_nxt;
  logic [CMD_WIDE-1:0] rdata_q, rdata_nxt;
  logic                wr_done_q, wr_done_nxt;
  logic                rsp_valid_q, rsp_valid_nxt;
  logic                accept;

  // req_ready is the only combinational output; it drops with rst_n itself
  assign bus.req_ready = (state == ST_IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cmd_nxt       = CMD_IDLE;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    rdata_nxt     = rdata_q;
    wr_done_nxt   = 1'b0;
    rsp_valid_nxt = rsp_valid_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          addr_nxt  = bus.req_addr;
          wdata_nxt = bus.req_wdata;
          if (bus.req_wr) begin
            state_nxt   = ST_WR;
            cmd_nxt     = CMD_WR;
            wr_done_nxt = 1'b1;
          end else begin
            state_nxt = ST_RD_PRE;
            cmd_nxt   = CMD_RD;
            cnt_nxt   = LAT_INIT;
          end
        end
      end
      ST_WR: state_nxt = ST_IDLE;
      ST_RD_PRE: begin
        // counter hits zero on the cycle cmd_data_out carries the read data
        if (cnt == 4'd0) begin
          rdata_nxt     = bus.cmd_data_out;
          rsp_valid_nxt = 1'b1;
          state_nxt     = ST_RD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RD: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      cmd_q       <= CMD_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wr_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cmd_q       <= cmd_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      rdata_q     <= rdata_nxt;
      wr_done_q   <= wr_done_nxt;
      rsp_valid_q <= rsp_valid_nxt;
    end
  end

  assign bus.cmd         = cmd_q;
  assign bus.cmd_addr    = addr_q;
  assign bus.cmd_data_in = wdata_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Bench for reg_cmd_master: one instance with RD_LAT=1 and one with RD_LAT=3,
// each backed by a small register-block model with its own read latency.
module tb_reg_cmd_master;
  import mcdf_reg_pkg::*;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rdq1[$];
  logic [31:0] rdq3[$];
  logic [39:0] wrq1[$];
  logic [39:0] wrq3[$];
  logic        prev_v1 = 1'b0;
  logic        prev_v3 = 1'b0;
  vec_t        vecs[8];

  reg_cmd_master_if #(.CMD_WIDE(32), .WL_WIDE(8)) bus1 ();
  reg_cmd_master_if #(.CMD_WIDE(32), .WL_WIDE(8)) bus3 ();

  reg_cmd_master #(.CMD_WIDE(32), .WL_WIDE(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  reg_cmd_master #(.CMD_WIDE(32), .WL_WIDE(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register block models; reset contents: 0 everywhere except 0x04 = 7
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe1;
  logic [31:0] p3a, p3b, p3c;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem1[i] <= (i == 4) ? 32'd7 : 32'd0;
    end else if (bus1.cmd == CMD_WR) begin
      mem1[bus1.cmd_addr] <= bus1.cmd_data_in;
    end
    pipe1 <= (bus1.cmd == CMD_RD) ? mem1[bus1.cmd_addr] : 32'hDEAD_BEEF;
  end
  assign bus1.cmd_data_out = pipe1;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem3[i] <= (i == 4) ? 32'd7 : 32'd0;
    end else if (bus3.cmd == CMD_WR) begin
      mem3[bus3.cmd_addr] <= bus3.cmd_data_in;
    end
    p3a <= (bus3.cmd == CMD_RD) ? mem3[bus3.cmd_addr] : 32'hDEAD_0003;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign bus3.cmd_data_out = p3c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [39:0] e;
    chk("cmd1_legal", 32'(bus1.cmd == 2'b10), 0);
    chk("cmd3_legal", 32'(bus3.cmd == 2'b10), 0);
    chk("wr_done1_vs_cmd", 32'(bus1.wr_done), 32'(bus1.cmd == CMD_WR));
    chk("wr_done3_vs_cmd", 32'(bus3.wr_done), 32'(bus3.cmd == CMD_WR));
    if (bus1.cmd == CMD_WR) begin
      if (wrq1.size() == 0) chk("wr1_unexpected", 1, 0);
      else begin
        e = wrq1.pop_front();
        chk("wr1_addr", 32'(bus1.cmd_addr), 32'(e[39:32]));
        chk("wr1_data", bus1.cmd_data_in, e[31:0]);
      end
    end
    if (bus3.cmd == CMD_WR) begin
      if (wrq3.size() == 0) chk("wr3_unexpected", 1, 0);
      else begin
        e = wrq3.pop_front();
        chk("wr3_addr", 32'(bus3.cmd_addr), 32'(e[39:32]));
        chk("wr3_data", bus3.cmd_data_in, e[31:0]);
      end
    end
    if (bus1.rsp_valid && !prev_v1) begin
      if (rdq1.size() == 0) chk("rsp1_unexpected", 1, 0);
      else chk("rsp1_rdata", bus1.rsp_rdata, rdq1.pop_front());
    end
    if (bus3.rsp_valid && !prev_v3) begin
      if (rdq3.size() == 0) chk("rsp3_unexpected", 1, 0);
      else chk("rsp3_rdata", bus3.rsp_rdata, rdq3.pop_front());
    end
    prev_v1 = bus1.rsp_valid;
    prev_v3 = bus3.rsp_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic send1(input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    int n = 0;
    bus1.req_valid = 1'b1;
    bus1.req_wr    = wr;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    if (wr) wrq1.push_back({addr, wdata});
    else    rdq1.push_back(exp);
    while (!bus1.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("req1_accept_timeout", 1, 0);
    tick();
    bus1.req_valid = 1'b0;
  endtask

  task automatic wait_rsp1();
    int n = 0;
    bus1.rsp_ready = 1'b1;
    while (!bus1.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("rsp1_timeout", 1, 0);
    tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, REG_SLV0_STAT, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, REG_SLV0_STAT, 32'h0,         32'h1234_5678};
    vecs[2] = '{1'b0, REG_SLV0_CTRL, 32'h0,         32'hFFFF_FFFF};
    vecs[3] = '{1'b1, REG_SLV1_CTRL, 32'h5A5A_0001, 32'h0};
    vecs[4] = '{1'b0, REG_SLV1_CTRL, 32'h0,         32'h5A5A_0001};
    vecs[5] = '{1'b0, REG_SLV2_CTRL, 32'h0,         32'h0000_00A5};
    vecs[6] = '{1'b1, REG_LAST,      32'h8000_0001, 32'h0};
    vecs[7] = '{1'b0, REG_LAST,      32'h0,         32'h8000_0001};

    rst_n = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_wr = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.rsp_ready = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_wr = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
    bus3.rsp_ready = 1'b1;

    // Reset held 5 cycles, then release
    repeat (5) tick();
    chk("rst_req_ready_low", 32'(bus1.req_ready), 0);
    chk("rst_cmd_idle", 32'(bus1.cmd), 32'(CMD_IDLE));
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", 32'(bus1.req_ready), 1);
    chk("rel_cmd", 32'(bus1.cmd), 0);
    chk("rel_cmd_addr", 32'(bus1.cmd_addr), 0);
    chk("rel_cmd_data_in", bus1.cmd_data_in, 0);
    chk("rel_wr_done", 32'(bus1.wr_done), 0);
    chk("rel_rsp_valid", 32'(bus1.rsp_valid), 0);
    chk("rel_rsp_rdata", bus1.rsp_rdata, 0);
    chk("rel3_req_ready", 32'(bus3.req_ready), 1);

    // Single write, all-ones data
    bus1.req_valid = 1'b1; bus1.req_wr = 1'b1;
    bus1.req_addr = REG_SLV0_CTRL; bus1.req_wdata = 32'hFFFF_FFFF;
    wrq1.push_back({REG_SLV0_CTRL, 32'hFFFF_FFFF});
    tick();
    bus1.req_valid = 1'b0;
    chk("wr_cmd", 32'(bus1.cmd), 32'(CMD_WR));
    chk("wr_cmd_addr", 32'(bus1.cmd_addr), 0);
    chk("wr_cmd_data", bus1.cmd_data_in, 32'hFFFF_FFFF);
    chk("wr_done_pulse", 32'(bus1.wr_done), 1);
    chk("wr_busy_ready", 32'(bus1.req_ready), 0);
    tick();
    chk("wr_cmd_back_idle", 32'(bus1.cmd), 0);
    chk("wr_done_cleared", 32'(bus1.wr_done), 0);
    chk("wr_ready_back", 32'(bus1.req_ready), 1);
    chk("wr_data_held", bus1.cmd_data_in, 32'hFFFF_FFFF);

    // Read with a stalled consumer; address noise while busy must be ignored
    bus1.rsp_ready = 1'b0;
    bus1.req_valid = 1'b1; bus1.req_wr = 1'b0; bus1.req_addr = REG_SLV1_CTRL;
    rdq1.push_back(32'd7);
    tick();
    bus1.req_valid = 1'b0;
    bus1.req_addr  = 8'hEE;
    chk("rd_cmd_rd", 32'(bus1.cmd), 32'(CMD_RD));
    chk("rd_cmd_addr", 32'(bus1.cmd_addr), 32'(REG_SLV1_CTRL));
    chk("rd_busy_ready", 32'(bus1.req_ready), 0);
    tick();
    chk("rd_cmd_one_cycle", 32'(bus1.cmd), 0);
    chk("rd_rsp_not_yet", 32'(bus1.rsp_valid), 0);
    tick();
    chk("rd_rsp_valid", 32'(bus1.rsp_valid), 1);
    chk("rd_rsp_rdata", bus1.rsp_rdata, 32'd7);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rd_hold_valid", 32'(bus1.rsp_valid), 1);
      chk("rd_hold_rdata", bus1.rsp_rdata, 32'd7);
      chk("rd_hold_addr", 32'(bus1.cmd_addr), 32'(REG_SLV1_CTRL));
      chk("rd_hold_ready", 32'(bus1.req_ready), 0);
    end
    bus1.rsp_ready = 1'b1;
    tick();
    chk("rd_rsp_cleared", 32'(bus1.rsp_valid), 0);
    chk("rd_ready_back", 32'(bus1.req_ready), 1);

    // Read-after-write with the read request held through the write cycle
    send1(1'b1, REG_SLV2_CTRL, 32'h0000_00A5, 32'h0);
    bus1.req_valid = 1'b1; bus1.req_wr = 1'b0; bus1.req_addr = REG_SLV2_CTRL;
    rdq1.push_back(32'h0000_00A5);
    chk("raw_held_not_ready", 32'(bus1.req_ready), 0);
    tick();
    chk("raw_ready_in_idle", 32'(bus1.req_ready), 1);
    tick();
    bus1.req_valid = 1'b0;
    chk("raw_rd_cmd", 32'(bus1.cmd), 32'(CMD_RD));
    wait_rsp1();

    // Table of mixed transactions
    for (int i = 0; i < 8; i++) begin
      send1(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      if (!vecs[i].wr) wait_rsp1();
    end

    // Reset during RD_PRE aborts the read; no stale response afterwards
    bus1.req_valid = 1'b1; bus1.req_wr = 1'b0; bus1.req_addr = REG_SLV1_CTRL;
    tick();
    bus1.req_valid = 1'b0;
    chk("abort_rd_cmd", 32'(bus1.cmd), 32'(CMD_RD));
    rst_n = 1'b0;
    #1;
    chk("abort_cmd_async", 32'(bus1.cmd), 0);
    chk("abort_rsp_valid", 32'(bus1.rsp_valid), 0);
    chk("abort_req_ready", 32'(bus1.req_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("abort_no_stale", 32'(bus1.rsp_valid), 0);
    send1(1'b0, REG_SLV1_CTRL, 32'h0, 32'd7);
    wait_rsp1();

    // RD_LAT=3 instance: response 4 cycles after the cmd=RD cycle
    bus3.req_valid = 1'b1; bus3.req_wr = 1'b0; bus3.req_addr = REG_SLV1_CTRL;
    rdq3.push_back(32'd7);
    tick();
    bus3.req_valid = 1'b0;
    chk("lat3_cmd_rd", 32'(bus3.cmd), 32'(CMD_RD));
    n = 0;
    while (!bus3.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("lat3_latency", 32'(n), 4);
    chk("lat3_rdata", bus3.rsp_rdata, 32'd7);
    tick();
    chk("lat3_rsp_cleared", 32'(bus3.rsp_valid), 0);
    chk("lat3_ready_back", 32'(bus3.req_ready), 1);

    repeat (2) tick();
    chk("wrq1_drained", 32'(wrq1.size()), 0);
    chk("rdq1_drained", 32'(rdq1.size()), 0);
    chk("wrq3_drained", 32'(wrq3.size()), 0);
    chk("rdq3_drained", 32'(rdq3.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
